rob_v2: RTL and testbench
=========================

Name: rob_v2

Overview:
- Second-generation reorder buffer for the out-of-order backend. Sits between rename/dispatch and ARF/RAT/store buffer.
- Adds the following over the first generation:
  - Parametrised per-class commit limits.
  - Wrap-bit pointers for exact full/empty detection.
  - Per-entry valid bits that filter stray writebacks.
  - In-place commit of a mispredicted branch.
  - Exception state machine that drains the store buffer before the flush.

Parameters:
- ROB_DEPTH, 64, entry count; must be a power of 2.
- DISPATCH_WIDTH, 4, dispatch lanes.
- COMMIT_WIDTH, 4, commit lanes.
- WB_WIDTH, 4, writeback ports.
- MAX_COMMIT_BR, 1, max branches retired per cycle.
- MAX_COMMIT_ST, 1, max stores retired per cycle.
- MAX_COMMIT_LD, 2, max loads retired per cycle.
- SB_DEPTH, 16, store buffer depth; SB_W = $clog2(SB_DEPTH).
- IDX_W, $clog2(ROB_DEPTH), entry index width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- dispatch_valid_i  in  DISPATCH_WIDTH  lane valids; must be contiguous from lane 0
- dispatch_pc_i  in  DISPATCH_WIDTH x PLEN  instruction PC
- dispatch_fu_type_i  in  DISPATCH_WIDTH x fu_e  functional unit
- dispatch_areg_i  in  DISPATCH_WIDTH x 5  architectural destination
- dispatch_is_store_i  in  DISPATCH_WIDTH  store flag
- dispatch_sb_id_i  in  DISPATCH_WIDTH x SB_W  store buffer slot
- dispatch_ready_o  out  1  all lanes accepted this cycle
- dispatch_rob_index_o  out  DISPATCH_WIDTH x IDX_W  tail+i
- wb_valid_i, wb_rob_index_i, wb_data_i, wb_exception_i, wb_ecause_i[5], wb_is_mispred_i, wb_redirect_pc_i  in  per WB_WIDTH lane  writeback
- sb_empty_i  in  1  store buffer holds no committed stores
- commit_valid_o, commit_pc_o, commit_we_o, commit_areg_o, commit_wdata_o, commit_rob_index_o, commit_is_store_o, commit_sb_id_o  out  per COMMIT_WIDTH lane  retire info
- flush_o  out  1  one-cycle flush pulse
- flush_pc_o  out  PLEN  redirect target
- flush_cause_o  out  5  ecause; 0 on mispredict
- flush_is_exc_o  out  1  flush caused by exception
- rob_count_o  out  IDX_W+1  occupancy
- rob_empty_o, rob_full_o  out  1  status
- perf_commit_o, perf_stall_o  out  32  counters (see Optional Feature)

Behaviour:
- Pointers: head and tail are IDX_W+1 bits.
  - Empty when head equals tail.
  - count = tail - head.
  - Full when count == ROB_DEPTH.
- dispatch_ready_o = (ROB_DEPTH - count >= DISPATCH_WIDTH) && state==RUN.
- Dispatch fires when ready && |valid.
  - Entry tail+i is written for each valid lane: valid=1, complete=0, exception=0, mispred=0.
  - Tail advances by popcount; lanes wrap modulo ROB_DEPTH.
- Writeback to an entry with valid=0 is ignored.
  - Two WB lanes hitting the same index in one cycle: the higher lane wins.
  - Writeback to an entry dispatched in the same cycle is ignored (illegal).
- Commit is combinational from registered state.
  - Lane i examines head+i while i < count and no earlier lane stopped.
  - Class limits count from lane 0; the first lane exceeding a limit stops itself and all later lanes.
- Per lane, checked in order:
  - Incomplete entry: stop.
  - Exception at i>0: stop; the entry becomes head next cycle.
  - Exception at i==0: no commit; RUN->DRAIN with pc/ecause latched.
  - Mispredict: commit this lane normally, including register write. Assert flush_o the same cycle with redirect_pc and flush_is_exc_o=0. Block all later lanes.
  - Otherwise: commit normally.
- Normal commit outputs:
  - commit_we_o = areg!=0.
  - commit_is_store_o and commit_sb_id_o are taken from the entry.
  - The retired entry's valid bit is cleared.
- State machine:
  - RUN -> DRAIN on head exception.
  - DRAIN holds (no dispatch, no commit) until sb_empty_i==1, then goes to FLUSH.
  - FLUSH asserts flush_o=1 for one cycle with the latched pc/cause and flush_is_exc_o=1, then returns to RUN.
  - If sb_empty_i is already 1 on DRAIN entry, FLUSH follows on the next cycle.
- Any flush_o: at the next edge head=tail=0, all valid bits clear, state=RUN. A dispatch in the flush cycle is dropped.
- Reset values:
  - Pointers 0, valid bits 0, state RUN.
  - flush_o=0, commit_valid_o=0, rob_empty_o=1, rob_full_o=0, dispatch_ready_o=1, counters 0.
  - Reset asserted mid-DRAIN aborts the drain with no flush pulse.

Optional Feature:
- Macro ROB_PERF_CNT_EN.
- When defined:
  - perf_commit_o accumulates committed instructions per cycle.
  - perf_stall_o counts cycles with count>0 and zero commits.
  - Both wrap at 2^32 and clear on reset and on nothing else.
- When undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Dispatch 4 then 4 more; WB all 8 complete -> commits of 4 then 4 in consecutive cycles; rob_empty_o=1 afterwards.
- Fill to 64 (ROB_DEPTH) -> dispatch_ready_o=0 at count 61; commit 4 -> ready returns; pointers wrap; indices 62,63,0,1 observed.
- Head block holds branch, branch, store, store, all complete -> cycle 1 commits one branch; cycle 2 commits branch+store; cycle 3 commits store.
- Lane 1 branch mispredicts with redirect 0x8000_1000 and lane 2 complete -> lanes 0 and 1 commit; flush_o=1, flush_pc_o=0x8000_1000; next cycle count=0.
- Head exception with ecause 2 and sb_empty_i=0 for 3 cycles -> no commit or dispatch during the hold; flush_o=1 with the instruction PC, cause 2, flush_is_exc_o=1 one cycle after sb_empty_i rises.
- WB to an invalid index 10 with ROB empty -> no state change; rst_ni pulsed during DRAIN -> no flush_o, outputs at reset values.

Source files
------------

// File: rtl/rob_v2.sv
// rob_v2: reorder buffer with wrap-bit pointers, class-limited in-order commit,
// in-place mispredict commit and store-buffer drain before exception flush. Optional perf counters: ROB_PERF_CNT_EN.
package rob_v2_pkg;
  localparam int unsigned PLEN = 32;
  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    FU_NONE   = 3'd0,
    FU_ALU    = 3'd1,
    FU_BRANCH = 3'd2,
    FU_LOAD   = 3'd3,
    FU_STORE  = 3'd4,
    FU_MULT   = 3'd5,
    FU_CSR    = 3'd6
  } fu_e;
endpackage

module rob_v2
  import rob_v2_pkg::*;
#(
  parameter int unsigned ROB_DEPTH      = 64,
  parameter int unsigned DISPATCH_WIDTH = 4,
  parameter int unsigned COMMIT_WIDTH   = 4,
  parameter int unsigned WB_WIDTH       = 4,
  parameter int unsigned MAX_COMMIT_BR  = 1,
  parameter int unsigned MAX_COMMIT_ST  = 1,
  parameter int unsigned MAX_COMMIT_LD  = 2,
  parameter int unsigned SB_DEPTH       = 16,
  parameter int unsigned SB_W           = $clog2(SB_DEPTH),
  parameter int unsigned IDX_W          = $clog2(ROB_DEPTH)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [DISPATCH_WIDTH-1:0]             dispatch_valid_i,
  input  logic [DISPATCH_WIDTH-1:0][PLEN-1:0]   dispatch_pc_i,
  input  fu_e  [DISPATCH_WIDTH-1:0]             dispatch_fu_type_i,
  input  logic [DISPATCH_WIDTH-1:0][4:0]        dispatch_areg_i,
  input  logic [DISPATCH_WIDTH-1:0]             dispatch_is_store_i,
  input  logic [DISPATCH_WIDTH-1:0][SB_W-1:0]   dispatch_sb_id_i,
  output logic                                  dispatch_ready_o,
  output logic [DISPATCH_WIDTH-1:0][IDX_W-1:0]  dispatch_rob_index_o,
  input  logic [WB_WIDTH-1:0]                   wb_valid_i,
  input  logic [WB_WIDTH-1:0][IDX_W-1:0]        wb_rob_index_i,
  input  logic [WB_WIDTH-1:0][XLEN-1:0]         wb_data_i,
  input  logic [WB_WIDTH-1:0]                   wb_exception_i,
  input  logic [WB_WIDTH-1:0][4:0]              wb_ecause_i,
  input  logic [WB_WIDTH-1:0]                   wb_is_mispred_i,
  input  logic [WB_WIDTH-1:0][PLEN-1:0]         wb_redirect_pc_i,
  input  logic                                  sb_empty_i,
  output logic [COMMIT_WIDTH-1:0]               commit_valid_o,
  output logic [COMMIT_WIDTH-1:0][PLEN-1:0]     commit_pc_o,
  output logic [COMMIT_WIDTH-1:0]               commit_we_o,
  output logic [COMMIT_WIDTH-1:0][4:0]          commit_areg_o,
  output logic [COMMIT_WIDTH-1:0][XLEN-1:0]     commit_wdata_o,
  output logic [COMMIT_WIDTH-1:0][IDX_W-1:0]    commit_rob_index_o,
  output logic [COMMIT_WIDTH-1:0]               commit_is_store_o,
  output logic [COMMIT_WIDTH-1:0][SB_W-1:0]     commit_sb_id_o,
  output logic                                  flush_o,
  output logic [PLEN-1:0]                       flush_pc_o,
  output logic [4:0]                            flush_cause_o,
  output logic                                  flush_is_exc_o,
  output logic [IDX_W:0]                        rob_count_o,
  output logic                                  rob_empty_o,
  output logic                                  rob_full_o,
  output logic [31:0]                           perf_commit_o,
  output logic [31:0]                           perf_stall_o
);

  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned DCNT_W = $clog2(DISPATCH_WIDTH + 1);
  localparam int unsigned CCNT_W = $clog2(COMMIT_WIDTH + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FLUSH} state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     head_q, tail_q, count;
  logic [ROB_DEPTH-1:0] valid_q;
  logic [PLEN-1:0]      exc_pc_q;
  logic [4:0]           exc_cause_q;

  logic [PLEN-1:0]      pc_q       [ROB_DEPTH];
  fu_e                  fu_q       [ROB_DEPTH];
  logic [4:0]           areg_q     [ROB_DEPTH];
  logic [SB_W-1:0]      sb_id_q    [ROB_DEPTH];
  logic [XLEN-1:0]      data_q     [ROB_DEPTH];
  logic [4:0]           ecause_q   [ROB_DEPTH];
  logic [PLEN-1:0]      redirect_q [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] complete_q, exc_q, mispred_q, is_store_q;

  logic [DCNT_W-1:0]    n_disp;
  logic [CCNT_W-1:0]    n_commit;
  logic                 dispatch_fire;
  logic                 head_exc, mispred_flush, stop;
  logic [PLEN-1:0]      mispred_pc;
  int unsigned          br_cnt, st_cnt, ld_cnt;

  assign count            = tail_q - head_q;
  assign rob_count_o      = count;
  assign rob_empty_o      = (head_q == tail_q);
  assign rob_full_o       = (count == PTR_W'(ROB_DEPTH));
  assign dispatch_ready_o = ((PTR_W'(ROB_DEPTH) - count) >= PTR_W'(DISPATCH_WIDTH)) && (state_q == ST_RUN);
  assign dispatch_fire    = dispatch_ready_o && (|dispatch_valid_i) && !flush_o;

  // Dispatch slot indices and lane popcount
  always_comb begin
    n_disp = '0;
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      dispatch_rob_index_o[i] = tail_q[IDX_W-1:0] + IDX_W'(i);
      n_disp = n_disp + DCNT_W'(dispatch_valid_i[i]);
    end
  end

  // In-order commit selection from the head; first blocking lane stops all later lanes
  always_comb begin
    commit_valid_o    = '0;
    commit_we_o       = '0;
    commit_pc_o       = '0;
    commit_areg_o     = '0;
    commit_wdata_o    = '0;
    commit_rob_index_o = '0;
    commit_is_store_o = '0;
    commit_sb_id_o    = '0;
    n_commit          = '0;
    head_exc          = 1'b0;
    mispred_flush     = 1'b0;
    mispred_pc        = '0;
    stop              = 1'b0;
    br_cnt            = 0;
    st_cnt            = 0;
    ld_cnt            = 0;
    for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
      commit_rob_index_o[i] = head_q[IDX_W-1:0] + IDX_W'(i);
      commit_pc_o[i]        = pc_q[commit_rob_index_o[i]];
      commit_areg_o[i]      = areg_q[commit_rob_index_o[i]];
      commit_wdata_o[i]     = data_q[commit_rob_index_o[i]];
      commit_is_store_o[i]  = is_store_q[commit_rob_index_o[i]];
      commit_sb_id_o[i]     = sb_id_q[commit_rob_index_o[i]];
      if (!stop && (state_q == ST_RUN) && (PTR_W'(i) < count)) begin
        if (!complete_q[commit_rob_index_o[i]]) begin
          stop = 1'b1;
        end else if (exc_q[commit_rob_index_o[i]]) begin
          stop = 1'b1;
          if (i == 0) head_exc = 1'b1;
        end else if ((fu_q[commit_rob_index_o[i]] == FU_BRANCH && br_cnt == MAX_COMMIT_BR) ||
                     (is_store_q[commit_rob_index_o[i]] && st_cnt == MAX_COMMIT_ST) ||
                     (fu_q[commit_rob_index_o[i]] == FU_LOAD && ld_cnt == MAX_COMMIT_LD)) begin
          stop = 1'b1;
        end else begin
          commit_valid_o[i] = 1'b1;
          commit_we_o[i]    = (areg_q[commit_rob_index_o[i]] != 5'd0);
          n_commit          = n_commit + CCNT_W'(1);
          if (fu_q[commit_rob_index_o[i]] == FU_BRANCH) br_cnt++;
          if (is_store_q[commit_rob_index_o[i]]) st_cnt++;
          if (fu_q[commit_rob_index_o[i]] == FU_LOAD) ld_cnt++;
          if (mispred_q[commit_rob_index_o[i]]) begin
            stop          = 1'b1;
            mispred_flush = 1'b1;
            mispred_pc    = redirect_q[commit_rob_index_o[i]];
          end
        end
      end
    end
  end

  // Exception/flush state machine: next state and flush outputs
  always_comb begin
    state_d        = state_q;
    flush_o        = 1'b0;
    flush_pc_o     = '0;
    flush_cause_o  = '0;
    flush_is_exc_o = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (head_exc) begin
          state_d = ST_DRAIN;
        end else if (mispred_flush) begin
          flush_o    = 1'b1;
          flush_pc_o = mispred_pc;
        end
      end
      ST_DRAIN: begin
        if (sb_empty_i) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush_o        = 1'b1;
        flush_pc_o     = exc_pc_q;
        flush_cause_o  = exc_cause_q;
        flush_is_exc_o = 1'b1;
        state_d        = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Pointers, valid bits and state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      head_q      <= '0;
      tail_q      <= '0;
      valid_q     <= '0;
      exc_pc_q    <= '0;
      exc_cause_q <= '0;
    end else begin
      state_q <= state_d;
      if (head_exc) begin
        exc_pc_q    <= pc_q[head_q[IDX_W-1:0]];
        exc_cause_q <= ecause_q[head_q[IDX_W-1:0]];
      end
      if (flush_o) begin
        head_q  <= '0;
        tail_q  <= '0;
        valid_q <= '0;
      end else begin
        head_q <= head_q + PTR_W'(n_commit);
        if (dispatch_fire) tail_q <= tail_q + PTR_W'(n_disp);
        for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
          if (dispatch_fire && dispatch_valid_i[i]) valid_q[dispatch_rob_index_o[i]] <= 1'b1;
        end
        for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
          if (commit_valid_o[i]) valid_q[commit_rob_index_o[i]] <= 1'b0;
        end
      end
    end
  end

  // Entry payload; writebacks to non-live entries are dropped, higher lane wins
  always_ff @(posedge clk_i) begin
    for (int unsigned j = 0; j < WB_WIDTH; j++) begin
      if (wb_valid_i[j] && valid_q[wb_rob_index_i[j]]) begin
        complete_q[wb_rob_index_i[j]] <= 1'b1;
        data_q[wb_rob_index_i[j]]     <= wb_data_i[j];
        exc_q[wb_rob_index_i[j]]      <= wb_exception_i[j];
        ecause_q[wb_rob_index_i[j]]   <= wb_ecause_i[j];
        mispred_q[wb_rob_index_i[j]]  <= wb_is_mispred_i[j];
        redirect_q[wb_rob_index_i[j]] <= wb_redirect_pc_i[j];
      end
    end
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      if (dispatch_fire && dispatch_valid_i[i]) begin
        pc_q[dispatch_rob_index_o[i]]       <= dispatch_pc_i[i];
        fu_q[dispatch_rob_index_o[i]]       <= dispatch_fu_type_i[i];
        areg_q[dispatch_rob_index_o[i]]     <= dispatch_areg_i[i];
        is_store_q[dispatch_rob_index_o[i]] <= dispatch_is_store_i[i];
        sb_id_q[dispatch_rob_index_o[i]]    <= dispatch_sb_id_i[i];
        complete_q[dispatch_rob_index_o[i]] <= 1'b0;
        exc_q[dispatch_rob_index_o[i]]      <= 1'b0;
        mispred_q[dispatch_rob_index_o[i]]  <= 1'b0;
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commit_q, perf_stall_q;

  // Free-running retire and stall counters; cleared by reset only
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_commit_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_commit_q <= perf_commit_q + 32'(n_commit);
      if ((count != '0) && (n_commit == '0)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_commit_o = perf_commit_q;
  assign perf_stall_o  = perf_stall_q;
`else
  assign perf_commit_o = '0;
  assign perf_stall_o  = '0;
`endif

endmodule

// File: tb/tb_rob_v2.sv
// Randomized scoreboard bench for rob_v2: a queue-based ROB model predicts commits and
// flushes; a monitor compares them as the DUT presents them, then directed drain/reset checks.
module tb_rob_v2;
  import rob_v2_pkg::*;

  localparam int DEPTH = 64;
  localparam int DW = 4, CW = 4, WW = 4;
  localparam int MAX_BR = 1, MAX_ST = 1, MAX_LD = 2;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic [DW-1:0]        dispatch_valid_i;
  logic [DW-1:0][31:0]  dispatch_pc_i;
  fu_e  [DW-1:0]        dispatch_fu_type_i;
  logic [DW-1:0][4:0]   dispatch_areg_i;
  logic [DW-1:0]        dispatch_is_store_i;
  logic [DW-1:0][3:0]   dispatch_sb_id_i;
  logic                 dispatch_ready_o;
  logic [DW-1:0][5:0]   dispatch_rob_index_o;
  logic [WW-1:0]        wb_valid_i;
  logic [WW-1:0][5:0]   wb_rob_index_i;
  logic [WW-1:0][31:0]  wb_data_i;
  logic [WW-1:0]        wb_exception_i;
  logic [WW-1:0][4:0]   wb_ecause_i;
  logic [WW-1:0]        wb_is_mispred_i;
  logic [WW-1:0][31:0]  wb_redirect_pc_i;
  logic                 sb_empty_i;
  logic [CW-1:0]        commit_valid_o;
  logic [CW-1:0][31:0]  commit_pc_o;
  logic [CW-1:0]        commit_we_o;
  logic [CW-1:0][4:0]   commit_areg_o;
  logic [CW-1:0][31:0]  commit_wdata_o;
  logic [CW-1:0][5:0]   commit_rob_index_o;
  logic [CW-1:0]        commit_is_store_o;
  logic [CW-1:0][3:0]   commit_sb_id_o;
  logic                 flush_o;
  logic [31:0]          flush_pc_o;
  logic [4:0]           flush_cause_o;
  logic                 flush_is_exc_o;
  logic [6:0]           rob_count_o;
  logic                 rob_empty_o, rob_full_o;
  logic [31:0]          perf_commit_o, perf_stall_o;

  rob_v2 dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .dispatch_valid_i(dispatch_valid_i), .dispatch_pc_i(dispatch_pc_i),
    .dispatch_fu_type_i(dispatch_fu_type_i), .dispatch_areg_i(dispatch_areg_i),
    .dispatch_is_store_i(dispatch_is_store_i), .dispatch_sb_id_i(dispatch_sb_id_i),
    .dispatch_ready_o(dispatch_ready_o), .dispatch_rob_index_o(dispatch_rob_index_o),
    .wb_valid_i(wb_valid_i), .wb_rob_index_i(wb_rob_index_i), .wb_data_i(wb_data_i),
    .wb_exception_i(wb_exception_i), .wb_ecause_i(wb_ecause_i),
    .wb_is_mispred_i(wb_is_mispred_i), .wb_redirect_pc_i(wb_redirect_pc_i),
    .sb_empty_i(sb_empty_i),
    .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o), .commit_we_o(commit_we_o),
    .commit_areg_o(commit_areg_o), .commit_wdata_o(commit_wdata_o),
    .commit_rob_index_o(commit_rob_index_o), .commit_is_store_o(commit_is_store_o),
    .commit_sb_id_o(commit_sb_id_o),
    .flush_o(flush_o), .flush_pc_o(flush_pc_o), .flush_cause_o(flush_cause_o),
    .flush_is_exc_o(flush_is_exc_o),
    .rob_count_o(rob_count_o), .rob_empty_o(rob_empty_o), .rob_full_o(rob_full_o),
    .perf_commit_o(perf_commit_o), .perf_stall_o(perf_stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc; fu_e fu; logic [4:0] areg; logic st; logic [3:0] sb;
    logic comp; logic exc; logic mis; logic [4:0] cause; logic [31:0] data; logic [31:0] redir;
  } ent_t;
  typedef struct {
    int cyc; logic [31:0] pc; logic we; logic [4:0] areg; logic [31:0] data;
    logic [5:0] idx; logic st; logic [3:0] sb;
  } cexp_t;
  typedef struct { int cyc; logic [31:0] pc; logic [4:0] cause; logic exc; } fexp_t;

  ent_t  rob[$];
  cexp_t cq[$];
  fexp_t fq[$];
  int head = 0, mode = 0;  // mode: 0 run, 1 draining, 2 flushing
  logic [31:0] x_pc = '0;
  logic [4:0]  x_cause = '0;
  longint m_perf_c = 0, m_perf_s = 0;
  int cyc = 0;
  bit mon_en = 0;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic idle();
    dispatch_valid_i = '0; dispatch_pc_i = '0; dispatch_areg_i = '0;
    dispatch_is_store_i = '0; dispatch_sb_id_i = '0;
    for (int i = 0; i < DW; i++) dispatch_fu_type_i[i] = FU_NONE;
    wb_valid_i = '0; wb_rob_index_i = '0; wb_data_i = '0; wb_exception_i = '0;
    wb_ecause_i = '0; wb_is_mispred_i = '0; wb_redirect_pc_i = '0;
    sb_empty_i = 1'b1;
  endtask

  // Monitor: pop and compare whenever the DUT retires or flushes
  initial begin
    forever begin
      @(posedge clk_i); #2;
      if (mon_en) begin
        for (int i = 0; i < CW; i++) begin
          if (commit_valid_o[i]) begin
            if (cq.size() == 0) chk("commit_extra", 64'(commit_valid_o[i]), 64'(0));
            else begin
              cexp_t e;
              e = cq.pop_front();
              chk("commit_cycle", 64'(cyc), 64'(e.cyc));
              chk("commit_pc", 64'(commit_pc_o[i]), 64'(e.pc));
              chk("commit_idx", 64'(commit_rob_index_o[i]), 64'(e.idx));
              chk("commit_we", 64'(commit_we_o[i]), 64'(e.we));
              chk("commit_areg", 64'(commit_areg_o[i]), 64'(e.areg));
              chk("commit_wdata", 64'(commit_wdata_o[i]), 64'(e.data));
              chk("commit_store", 64'(commit_is_store_o[i]), 64'(e.st));
              chk("commit_sb_id", 64'(commit_sb_id_o[i]), 64'(e.sb));
            end
          end
        end
        if (flush_o) begin
          if (fq.size() == 0) chk("flush_extra", 64'(flush_o), 64'(0));
          else begin
            fexp_t f;
            f = fq.pop_front();
            chk("flush_cycle", 64'(cyc), 64'(f.cyc));
            chk("flush_pc", 64'(flush_pc_o), 64'(f.pc));
            chk("flush_cause", 64'(flush_cause_o), 64'(f.cause));
            chk("flush_is_exc", 64'(flush_is_exc_o), 64'(f.exc));
          end
        end
      end
    end
  end

  // One random cycle: check status, predict retire/flush, drive stimulus, advance model
  task automatic step();
    int nc = 0, br = 0, st = 0, ld = 0, nd;
    bit hexc = 0, fl = 0, ready, slow;
    logic [31:0] fpc = '0;
    ent_t d[DW];
    chk("count", 64'(rob_count_o), 64'(rob.size()));
    chk("empty", 64'(rob_empty_o), 64'(rob.size() == 0));
    chk("full", 64'(rob_full_o), 64'(rob.size() == DEPTH));
    ready = (DEPTH - rob.size() >= DW) && (mode == 0);
    chk("dispatch_ready", 64'(dispatch_ready_o), 64'(ready));
    chk("dispatch_index", 64'(dispatch_rob_index_o[0]), 64'((head + rob.size()) % DEPTH));
`ifdef ROB_PERF_CNT_EN
    chk("perf_commit", 64'(perf_commit_o), 64'(m_perf_c[31:0]));
    chk("perf_stall", 64'(perf_stall_o), 64'(m_perf_s[31:0]));
`else
    chk("perf_commit_off", 64'(perf_commit_o), 64'(0));
`endif
    if (mode == 0) begin
      for (int i = 0; i < CW && i < rob.size(); i++) begin
        ent_t e;
        e = rob[i];
        if (!e.comp) break;
        if (e.exc) begin
          if (i == 0) begin hexc = 1; x_pc = e.pc; x_cause = e.cause; end
          break;
        end
        if (e.fu == FU_BRANCH && br == MAX_BR) break;
        if (e.st && st == MAX_ST) break;
        if (e.fu == FU_LOAD && ld == MAX_LD) break;
        if (e.fu == FU_BRANCH) br++;
        if (e.st) st++;
        if (e.fu == FU_LOAD) ld++;
        cq.push_back('{cyc, e.pc, e.areg != 0, e.areg, e.data, 6'((head + i) % DEPTH), e.st, e.sb});
        nc++;
        if (e.mis) begin fl = 1; fpc = e.redir; break; end
      end
    end
    if (mode == 2) fq.push_back('{cyc, x_pc, x_cause, 1'b1});
    else if (fl) fq.push_back('{cyc, fpc, 5'd0, 1'b0});
    m_perf_c += nc;
    if (rob.size() > 0 && nc == 0) m_perf_s++;

    idle();
    nd = $urandom_range(0, DW);
    for (int i = 0; i < DW; i++) begin
      case ($urandom % 4)
        0: d[i].fu = FU_ALU;
        1: d[i].fu = FU_BRANCH;
        2: d[i].fu = FU_LOAD;
        default: d[i].fu = FU_STORE;
      endcase
      d[i].pc = {$urandom, 2'b00} & 32'hffff_fffc; d[i].st = (d[i].fu == FU_STORE);
      d[i].areg = 5'($urandom); d[i].sb = 4'($urandom);
      d[i].comp = 0; d[i].exc = 0; d[i].mis = 0; d[i].cause = '0; d[i].data = '0; d[i].redir = '0;
      dispatch_valid_i[i] = (i < nd);
      dispatch_pc_i[i] = d[i].pc; dispatch_fu_type_i[i] = d[i].fu; dispatch_areg_i[i] = d[i].areg;
      dispatch_is_store_i[i] = d[i].st; dispatch_sb_id_i[i] = d[i].sb;
    end
    slow = ((cyc / 150) % 2) == 0;
    for (int j = 0; j < WW; j++) begin
      wb_valid_i[j] = ($urandom % 100) < (slow ? 10 : 85);
      if (rob.size() > 0 && ($urandom % 10) < 8) wb_rob_index_i[j] = 6'((head + ($urandom % rob.size())) % DEPTH);
      else wb_rob_index_i[j] = 6'($urandom);
      wb_data_i[j] = $urandom; wb_exception_i[j] = ($urandom % 100) < 2;
      wb_ecause_i[j] = 5'($urandom_range(1, 31)); wb_is_mispred_i[j] = ($urandom % 100) < 5;
      wb_redirect_pc_i[j] = $urandom;
    end
    sb_empty_i = ($urandom % 100) < 30;

    if (mode == 2 || fl) begin
      rob.delete(); head = 0; mode = 0;
    end else begin
      for (int j = 0; j < WW; j++) begin
        int off;
        off = (int'(wb_rob_index_i[j]) - head + DEPTH) % DEPTH;
        if (wb_valid_i[j] && off < rob.size()) begin
          ent_t t;
          t = rob[off];
          t.comp = 1; t.data = wb_data_i[j]; t.exc = wb_exception_i[j];
          t.cause = wb_ecause_i[j]; t.mis = wb_is_mispred_i[j]; t.redir = wb_redirect_pc_i[j];
          rob[off] = t;
        end
      end
      for (int k = 0; k < nc; k++) void'(rob.pop_front());
      head = (head + nc) % DEPTH;
      if (hexc) mode = 1;
      else if (mode == 1 && sb_empty_i) mode = 2;
      if (ready) for (int i = 0; i < nd; i++) rob.push_back(d[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
    cyc++;
  endtask

  task automatic enter_drain(input logic [31:0] pc, input logic [4:0] cause);
    idle(); sb_empty_i = 1'b0;
    dispatch_valid_i[0] = 1'b1; dispatch_pc_i[0] = pc; dispatch_fu_type_i[0] = FU_ALU; dispatch_areg_i[0] = 5'd5;
    tick();
    dispatch_valid_i = '0;
    wb_valid_i[2] = 1'b1; wb_rob_index_i[2] = 6'd0; wb_exception_i[2] = 1'b1; wb_ecause_i[2] = cause;
    tick();
    wb_valid_i = '0;
    chk("exc_head_no_commit", 64'(commit_valid_o), 64'(0));
    tick();
  endtask

  initial begin
    idle();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_flush", 64'(flush_o), 64'(0));
    chk("rst_commit_valid", 64'(commit_valid_o), 64'(0));
    chk("rst_empty", 64'(rob_empty_o), 64'(1));
    chk("rst_full", 64'(rob_full_o), 64'(0));
    chk("rst_ready", 64'(dispatch_ready_o), 64'(1));
    chk("rst_perf", 64'({perf_commit_o, perf_stall_o}), 64'(0));
    rst_ni = 1'b1;
    mon_en = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      step();
    end
    #5;
    mon_en = 0;
    chk("commit_queue_drained", 64'(cq.size()), 64'(0));
    chk("flush_queue_drained", 64'(fq.size()), 64'(0));

    // Directed: stray writeback on empty ROB, drain hold, then reset mid-drain
    idle(); rst_ni = 1'b0; #2; rst_ni = 1'b1;
    wb_valid_i[0] = 1'b1; wb_rob_index_i[0] = 6'd10; wb_exception_i[0] = 1'b1; wb_ecause_i[0] = 5'd3;
    tick();
    idle();
    chk("stray_wb_count", 64'(rob_count_o), 64'(0));
    chk("stray_wb_empty", 64'(rob_empty_o), 64'(1));
    tick();
    chk("stray_wb_no_commit", 64'(commit_valid_o), 64'(0));
    chk("stray_wb_no_flush", 64'(flush_o), 64'(0));

    enter_drain(32'h0000_1234, 5'd2);
    for (int k = 0; k < 3; k++) begin
      dispatch_valid_i[0] = 1'b1;
      chk("drain_ready", 64'(dispatch_ready_o), 64'(0));
      chk("drain_commit", 64'(commit_valid_o), 64'(0));
      chk("drain_flush", 64'(flush_o), 64'(0));
      chk("drain_count", 64'(rob_count_o), 64'(1));
      if (k == 2) sb_empty_i = 1'b1;
      tick();
    end
    dispatch_valid_i = '0;
    chk("exc_flush", 64'(flush_o), 64'(1));
    chk("exc_flush_pc", 64'(flush_pc_o), 64'(32'h0000_1234));
    chk("exc_flush_cause", 64'(flush_cause_o), 64'(2));
    chk("exc_flush_is_exc", 64'(flush_is_exc_o), 64'(1));
    tick();
    chk("post_flush_count", 64'(rob_count_o), 64'(0));
    chk("post_flush_ready", 64'(dispatch_ready_o), 64'(1));

    enter_drain(32'h0000_5678, 5'd7);
    chk("drain2_ready", 64'(dispatch_ready_o), 64'(0));
    rst_ni = 1'b0; #1;
    sb_empty_i = 1'b1;
    chk("rst_drain_flush", 64'(flush_o), 64'(0));
    chk("rst_drain_count", 64'(rob_count_o), 64'(0));
    chk("rst_drain_ready", 64'(dispatch_ready_o), 64'(1));
    tick();
    rst_ni = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_drain_no_flush", 64'(flush_o), 64'(0));
      chk("rst_drain_no_commit", 64'(commit_valid_o), 64'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
